// File: rtl/kgp_pkg.sv
// Shared definitions for the kgp sequencer: FSM state encoding, opcode/function
// constants, and the PC-source and register-destination selectors.
package kgp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_IMM = 2'd1,
    PC_RA  = 2'd2,
    PC_RS  = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    DST_RS   = 2'd0,
    DST_RT   = 2'd1,
    DST_HILO = 2'd2,
    DST_RA   = 2'd3
  } rf_dst_t;

  localparam logic [1:0] OP_ALUI = 2'b00;
  localparam logic [1:0] OP_ALUR = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_SYS  = 2'b11;

  localparam logic [3:0] FN_ALUI_MAX = 4'b0100;
  localparam logic [3:0] FN_JRA      = 4'b0101;
  localparam logic [3:0] FN_JRS      = 4'b0110;
  localparam logic [3:0] FN_MUL      = 4'b0001;
  localparam logic [3:0] FN_MULU     = 4'b0010;
  localparam logic [3:0] FN_LOAD     = 4'b1001;
  localparam logic [3:0] FN_STORE    = 4'b1010;
  localparam logic [3:0] FN_CALL     = 4'b1000;
  localparam logic [3:0] FN_NOP      = 4'b0000;

endpackage

// File: rtl/kgp_branch_eval.sv
// Branch condition evaluation: fn 0-7 test z,c,s,v for set/clear in pairs;
// fn 1000 (call) and 1001 (jump) are always taken; anything above is never taken.
module kgp_branch_eval (
  input  logic [3:0] fn,
  input  logic       zflag,
  input  logic       cflag,
  input  logic       sflag,
  input  logic       vflag,
  output logic       taken
);

  logic sel_flag;

  always_comb begin
    sel_flag = zflag;
    case (fn[2:1])
      2'd0:    sel_flag = zflag;
      2'd1:    sel_flag = cflag;
      2'd2:    sel_flag = sflag;
      default: sel_flag = vflag;
    endcase

    taken = 1'b0;
    // Even fn wants the flag set, odd fn wants it clear.
    if (!fn[3])
      taken = sel_flag ^ fn[0];
    else if (fn[2:1] == 2'b00)
      taken = 1'b1;
  end

endmodule

// File: rtl/kgp_seq_ctrl.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT FSM with
// one-cycle strobes. Define KGP_SEQ_PERF_EN to build the retired-instruction counter.
module kgp_seq_ctrl
  import kgp_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [3:0]        fn,
  input  logic              zflag,
  input  logic              cflag,
  input  logic              sflag,
  input  logic              vflag,
  output logic              imem_en,
  output logic              ir_ld,
  output logic              opnd_ld,
  output logic              imm_sel,
  output logic [1:0]        pc_sel,
  output logic              pc_we,
  output logic              rf_we,
  output logic [1:0]        rf_dst,
  output logic              mem_we,
  output logic              flag_we,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        state,
  output logic [PERF_W-1:0] retired
);

  state_t state_q, state_d;
  logic   taken;
  logic   alu_imm, alu_reg, mem_op, is_load, is_store, is_mul, halt_op;

  kgp_branch_eval u_branch_eval (
    .fn    (fn),
    .zflag (zflag),
    .cflag (cflag),
    .sflag (sflag),
    .vflag (vflag),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign is_load  = (op == OP_ALUR) && (fn == FN_LOAD);
  assign is_store = (op == OP_ALUR) && (fn == FN_STORE);
  assign mem_op   = is_load || is_store;
  assign alu_imm  = (op == OP_ALUI) && (fn <= FN_ALUI_MAX);
  assign alu_reg  = (op == OP_ALUR) && !mem_op;
  assign is_mul   = (op == OP_ALUR) && ((fn == FN_MUL) || (fn == FN_MULU));
  assign halt_op  = (op == OP_SYS) && (fn != FN_NOP);

  always_comb begin
    state_d = state_q;
    imem_en = 1'b0;
    ir_ld   = 1'b0;
    opnd_ld = 1'b0;
    imm_sel = 1'b0;
    pc_sel  = PC_INC;
    pc_we   = 1'b0;
    rf_we   = 1'b0;
    rf_dst  = DST_RS;
    mem_we  = 1'b0;
    flag_we = 1'b0;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_en = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_ld   = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (alu_imm || alu_reg) begin
          opnd_ld = 1'b1;
          imm_sel = alu_imm;
          state_d = ST_WB;
        end else if (mem_op) begin
          state_d = ST_MEM;
        end else if (op == OP_BR) begin
          // Call writes PC+1 into ra in the same cycle the PC is redirected.
          pc_we   = 1'b1;
          pc_sel  = taken ? PC_IMM : PC_INC;
          rf_we   = (fn == FN_CALL);
          rf_dst  = (fn == FN_CALL) ? DST_RA : DST_RS;
          state_d = ST_FETCH;
        end else if ((op == OP_ALUI) && (fn == FN_JRA)) begin
          pc_we   = 1'b1;
          pc_sel  = PC_RA;
          state_d = ST_FETCH;
        end else if ((op == OP_ALUI) && (fn == FN_JRS)) begin
          pc_we   = 1'b1;
          pc_sel  = PC_RS;
          state_d = ST_FETCH;
        end else if (halt_op) begin
          state_d = ST_HALT;
        end else begin
          pc_we   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_we  = is_store;
        state_d = ST_WB;
      end
      ST_WB: begin
        pc_we   = 1'b1;
        rf_we   = !is_store;
        rf_dst  = is_load ? DST_RT : (is_mul ? DST_HILO : DST_RS);
        flag_we = !mem_op;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted = (state_q == ST_HALT);
  assign state  = state_q;

`ifdef KGP_SEQ_PERF_EN
  logic [PERF_W-1:0] retired_q;
  logic              retire;

  // An instruction completes in WB, or in EXEC when it leaves straight for FETCH/HALT.
  assign retire = (state_q == ST_WB) ||
                  ((state_q == ST_EXEC) && ((state_d == ST_FETCH) || (state_d == ST_HALT)));

  always_ff @(posedge clk) begin
    if (!rst_n)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + {{(PERF_W-1){1'b0}}, 1'b1};
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_kgp_seq_ctrl.sv
// Scoreboard bench for kgp_seq_ctrl: directed instructions push per-cycle expected
// outputs into a queue, a negedge monitor pops and compares them.
module tb_kgp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [1:0]  op;
  logic [3:0]  fn;
  logic        zflag, cflag, sflag, vflag;
  logic        imem_en, ir_ld, opnd_ld, imm_sel, pc_we, rf_we, mem_we, flag_we;
  logic        busy, halted;
  logic [1:0]  pc_sel, rf_dst;
  logic [2:0]  state;
  logic [31:0] retired;

  kgp_seq_ctrl #(.PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .fn(fn),
    .zflag(zflag), .cflag(cflag), .sflag(sflag), .vflag(vflag),
    .imem_en(imem_en), .ir_ld(ir_ld), .opnd_ld(opnd_ld), .imm_sel(imm_sel),
    .pc_sel(pc_sel), .pc_we(pc_we), .rf_we(rf_we), .rf_dst(rf_dst),
    .mem_we(mem_we), .flag_we(flag_we), .busy(busy), .halted(halted),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  state;
    logic        busy, halted, imem_en, ir_ld, opnd_ld, imm_sel;
    logic [1:0]  pc_sel;
    logic        pc_we, rf_we;
    logic [1:0]  rf_dst;
    logic        mem_we, flag_we;
    logic [31:0] retired;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  typedef enum int {C_ALUI, C_ALUR, C_MUL, C_LOAD, C_STORE, C_JRA, C_JRS,
                    C_BRT, C_BRN, C_CALL, C_NOP, C_HALT} cls_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ret = 0;

  function automatic obs_t mk(input logic [2:0] st);
    obs_t x = '0;
    x.state   = st;
    x.busy    = (st != 3'd0) && (st != 3'd6);
    x.halted  = (st == 3'd6);
    x.retired = exp_ret;
    return x;
  endfunction

  // Selector fields only matter while their strobe is asserted.
  function automatic obs_t mask(input obs_t x);
    obs_t y = x;
    if (!y.opnd_ld) y.imm_sel = 1'b0;
    if (!y.pc_we)   y.pc_sel  = 2'd0;
    if (!y.rf_we)   y.rf_dst  = 2'd0;
    return y;
  endfunction

  task automatic push(input obs_t o, input string tag);
    exp_t e;
    e.o   = o;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire_one();
`ifdef KGP_SEQ_PERF_EN
    exp_ret = exp_ret + 32'd1;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step();
    exp_ret = 0;
    push(mk(3'd0), "reset_idle");
    step();
    rst_n = 1'b1;
    push(mk(3'd0), "idle_hold");
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    push(mk(3'd0), "idle_start");
    step();
    start = 1'b0;
  endtask

  // flg = {z,c,s,v}; cls is the hand-classified expected behaviour.
  task automatic run_instr(input logic [1:0] o, input logic [3:0] f, input logic [3:0] flg,
                           input cls_t c, input string tag, input bit abort_in_mem = 1'b0);
    obs_t e;
    op = o;
    fn = f;
    {zflag, cflag, sflag, vflag} = flg;
    e = mk(3'd1); e.imem_en = 1'b1; push(e, {tag, "/fetch"});  step();
    e = mk(3'd2); e.ir_ld   = 1'b1; push(e, {tag, "/decode"}); step();
    e = mk(3'd3);
    case (c)
      C_ALUI:        begin e.opnd_ld = 1'b1; e.imm_sel = 1'b1; end
      C_ALUR, C_MUL: e.opnd_ld = 1'b1;
      C_JRA:         begin e.pc_we = 1'b1; e.pc_sel = 2'd2; end
      C_JRS:         begin e.pc_we = 1'b1; e.pc_sel = 2'd3; end
      C_BRT:         begin e.pc_we = 1'b1; e.pc_sel = 2'd1; end
      C_BRN, C_NOP:  e.pc_we = 1'b1;
      C_CALL:        begin e.pc_we = 1'b1; e.pc_sel = 2'd1; e.rf_we = 1'b1; e.rf_dst = 2'd3; end
      default:       ;
    endcase
    push(e, {tag, "/exec"});
    step();
    if (c == C_LOAD || c == C_STORE) begin
      if (abort_in_mem) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_ret = 0;
        push(mk(3'd0), {tag, "/mem_reset_idle"});
        step();
        return;
      end
      e = mk(3'd4); e.mem_we = (c == C_STORE); push(e, {tag, "/mem"}); step();
    end
    if (c inside {C_ALUI, C_ALUR, C_MUL, C_LOAD, C_STORE}) begin
      e = mk(3'd5);
      e.pc_we   = 1'b1;
      e.rf_we   = (c != C_STORE);
      e.rf_dst  = (c == C_LOAD) ? 2'd1 : ((c == C_MUL) ? 2'd2 : 2'd0);
      e.flag_we = (c inside {C_ALUI, C_ALUR, C_MUL});
      push(e, {tag, "/wb"});
      step();
    end
    retire_one();
  endtask

  initial begin : monitor
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{state: state, busy: busy, halted: halted, imem_en: imem_en, ir_ld: ir_ld,
              opnd_ld: opnd_ld, imm_sel: imm_sel, pc_sel: pc_sel, pc_we: pc_we,
              rf_we: rf_we, rf_dst: rf_dst, mem_we: mem_we, flag_we: flag_we,
              retired: retired};
        n_cmp++;
        if (mask(a) !== mask(e.o)) begin
          n_bad++;
          $display("FAIL %s: got %h required %h", e.tag, mask(a), mask(e.o));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0; start = 1'b0; op = 2'b00; fn = 4'b0000;
    zflag = 1'b0; cflag = 1'b0; sflag = 1'b0; vflag = 1'b0;
    step();
    do_reset();
    do_start();
    run_instr(2'b00, 4'b0000, 4'b0000, C_ALUI,  "alui");
    run_instr(2'b01, 4'b1010, 4'b1111, C_STORE, "store");
    run_instr(2'b10, 4'b0000, 4'b1000, C_BRT,   "bz_taken");
    run_instr(2'b10, 4'b0000, 4'b0000, C_BRN,   "bz_untaken");
    run_instr(2'b10, 4'b0011, 4'b1011, C_BRT,   "bnc_taken");
    run_instr(2'b10, 4'b0111, 4'b0001, C_BRN,   "bnv_untaken");
    run_instr(2'b10, 4'b0100, 4'b0010, C_BRT,   "bs_taken");
    run_instr(2'b10, 4'b1000, 4'b0000, C_CALL,  "call");
    run_instr(2'b10, 4'b1001, 4'b0000, C_BRT,   "jmp_always");
    run_instr(2'b10, 4'b1100, 4'b1111, C_BRN,   "br_undef");
    run_instr(2'b01, 4'b1001, 4'b0000, C_LOAD,  "load");
    run_instr(2'b01, 4'b0010, 4'b0000, C_MUL,   "mul");
    run_instr(2'b01, 4'b0101, 4'b0000, C_ALUR,  "alur");
    run_instr(2'b00, 4'b0101, 4'b0000, C_JRA,   "jr_ra");
    run_instr(2'b00, 4'b0110, 4'b0000, C_JRS,   "jr_rs");
    run_instr(2'b11, 4'b0000, 4'b0000, C_NOP,   "nop");
    run_instr(2'b00, 4'b1000, 4'b0000, C_NOP,   "undef_nop");
    run_instr(2'b11, 4'b0001, 4'b0000, C_HALT,  "halt");
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(mk(3'd6), "halt_hold");
      step();
    end
    start = 1'b0;
    do_reset();
    do_start();
    run_instr(2'b01, 4'b1010, 4'b0000, C_STORE, "store_abort", 1'b1);
    push(mk(3'd0), "post_abort_idle");
    step();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kgp_seq_ctrl.md
KGP_SEQ_CTRL -- requirements
Module: kgp_seq_ctrl

Interface
REQ-001 SHALL have parameter PERF_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  in  1  begin sequencing from IDLE; sampled only in IDLE.
REQ-005 SHALL have ports op  in  2 and fn  in  4  opcode and function field of the instruction register.
REQ-006 SHALL have ports zflag, cflag, sflag, vflag  in  1 each  current datapath flags.
REQ-007 SHALL have port imem_en  out  1  instruction BRAM read enable.
REQ-008 SHALL have port ir_ld  out  1  latch BRAM output into the instruction register.
REQ-009 SHALL have port opnd_ld  out  1  latch ALU operands; imm_sel  out  1  B operand = sign-extended imm when 1.
REQ-010 SHALL have port pc_sel  out  2  PC source: 0 PC+1, 1 imm[7:0], 2 reg[18] (ra), 3 reg[rs]; pc_we  out  1  PC write strobe.
REQ-011 SHALL have ports rf_we  out  1 and rf_dst  out  2  destination: 0 rs, 1 rt, 2 hi/lo pair (19/20), 3 ra (18).
REQ-012 SHALL have ports mem_we  out  1  data-memory write; flag_we  out  1  sign-flag update.
REQ-013 SHALL have ports busy  out  1, halted  out  1, state  out  3  current FSM state.
REQ-014 SHALL have port retired  out  PERF_W  retired-instruction count (see Configuration).

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; encoding in the shared package.
REQ-016 SHALL go IDLE->FETCH when start=1; IDLE otherwise holds.
REQ-017 SHALL go FETCH (imem_en=1)->DECODE (ir_ld=1)->EXEC unconditionally.
REQ-018 SHALL in EXEC assert opnd_ld for op=00 fn 0-4 (imm_sel=1) and op=01 non-memory fn (imm_sel=0), then go WB.
REQ-019 SHALL in EXEC for op=01 fn=1001 (load) or fn=1010 (store) go MEM; MEM asserts mem_we=1 for store only, then WB.
REQ-020 SHALL in WB assert pc_we with pc_sel=0, rf_we=1 with rf_dst=0 for ALU ops, 1 for load, 2 for fn 0001/0010 multiply; flag_we=1 for ALU/multiply; store: rf_we=0.
REQ-021 SHALL resolve op=10 in EXEC: fn 0-7 taken when flag z,z,c,c,s,s,v,v equals 1,0,1,0,1,0,1,0 respectively; fn 1001 always taken; taken -> pc_sel=1; untaken or fn>=1010 -> pc_sel=0; pc_we=1; next FETCH.
REQ-022 SHALL for op=10 fn=1000 (call) in EXEC assert rf_we, rf_dst=3 (PC+1 into ra), pc_we, pc_sel=1 in the same cycle.
REQ-023 SHALL for op=00 fn=0101 use pc_sel=2, fn=0110 pc_sel=3, pc_we=1 in EXEC, next FETCH.
REQ-024 SHALL treat op=11 fn=0000 as nop (pc_sel=0, pc_we in EXEC); op=11 any other fn -> HALT; undefined op/fn combos behave as nop.
REQ-025 SHALL hold HALT until reset; halted=1 in HALT only; busy=1 in all states except IDLE and HALT.
REQ-026 SHALL keep every strobe (imem_en, ir_ld, opnd_ld, pc_we, rf_we, mem_we, flag_we) one cycle wide; all outputs registered-state decodes, no strobe outside the named state.
REQ-027 SHALL give latencies: branch/jump/nop 3 cycles, ALU 4, load/store 5, start-to-first-fetch 1.

Reset
REQ-028 SHALL on rst_n=0 at a clock edge enter IDLE, all strobes 0, busy=0, halted=0, retired=0, including mid-instruction (an in-flight store not yet in MEM is dropped).

Configuration
REQ-029 SHALL with KGP_SEQ_PERF_EN defined increment retired by 1 on each instruction-completing cycle (last state before FETCH or HALT), wrapping modulo 2^PERF_W; without it retired is constant 0 and no counter flops exist.

Structure
REQ-030 SHALL place state encoding, op/fn constants, pc_sel and rf_dst enums in shared package kgp_pkg.
REQ-031 SHALL use one sub-module kgp_branch_eval (combinational fn+flags -> taken).

Verification
REQ-032 SHALL test reset then start=1, op=00 fn=0000: states IDLE,FETCH,DECODE,EXEC,WB; rf_we,flag_we,pc_we in cycle 4 with rf_dst=0.
REQ-033 SHALL test op=01 fn=1010: mem_we=1 exactly in MEM (cycle 4), rf_we never asserted, retired+1 with macro.
REQ-034 SHALL test op=10 fn=0000 with zflag=1 -> pc_sel=1 at EXEC; zflag=0 -> pc_sel=0.
REQ-035 SHALL test op=10 fn=1000: rf_we, rf_dst=3, pc_sel=1 in same EXEC cycle.
REQ-036 SHALL test op=11 fn=0001 -> HALT, halted=1, start ignored; rst_n=0 -> IDLE.
REQ-037 SHALL test rst_n=0 during MEM of a store -> IDLE next edge, mem_we=0.
